// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART link blocks (tx/rx tops, echo responder).
//   FRAME_WIDTH_DEF : default payload bits per UART frame
//   state_t         : echo responder FSM encoding (ST_IDLE .. ST_WAIT_DONE)
//   clog2()         : ceiling log2 for use in parameter expressions
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int FRAME_WIDTH_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_SEND      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  // Smallest r with 2**r >= value (value >= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO, parameterised width and depth (depth a power of two,
// minimum 2). Pointers wrap naturally; occupancy is tracked by an explicit
// level counter so full (level == DEPTH) and empty (level == 0) are exact.
// A push while full is accepted only when a pop happens in the same cycle.
// The head word is presented combinationally on o_rdata; the consumer is
// expected to register it when it pops.
//   i_clk, i_rst       : clock, asynchronous active-high reset
//   i_push, i_wdata    : write request and data
//   i_pop, o_rdata     : read request and head-of-queue data
//   o_full, o_empty    : occupancy flags
//   o_level            : number of stored words (0..DEPTH)
// ---------------------------------------------------------------------------
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  localparam int AW   = clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rd_ptr];

  assign w_pop_ok  = i_pop & ~o_empty;
  // At full, a same-cycle pop frees the slot the write lands in.
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  // Storage is not reset: contents are meaningless once the pointers clear.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_responder.sv
// ---------------------------------------------------------------------------
// uart_echo_responder
// Far-end loopback: every good frame received from uart_rx_top is queued
// and re-transmitted, in order, through uart_tx_top.
// Optional feature macro: UART_ECHO_ERR_CNT_EN adds err_cnt, a saturating
// count of received frames carrying a data or frame error.
//   sys_clk, reset        : clock, asynchronous active-high reset
//   uart_rx_dout/done     : received frame and its valid level
//   uart_rx_data_error    : parity/data error of the current frame
//   uart_rx_frame_error   : stop-bit error of the current frame
//   uart_tx_done          : transmitter idle/ready
//   uart_tx_en/din        : transmit request and frame
//   fifo_level            : frames buffered
//   overflow              : sticky, a good frame was lost to a full FIFO
//   busy                  : FSM active or frames pending
//   err_cnt (optional)    : errored-frame count, saturating at 255
// ---------------------------------------------------------------------------
module uart_echo_responder
  import uart_pkg::*;
#(
  parameter int FRAME_WIDTH  = FRAME_WIDTH_DEF,
  parameter int FIFO_DEPTH   = 8,
  parameter int DROP_ERRORED = 1,
  localparam int LW          = clog2(FIFO_DEPTH) + 1
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic [0:FRAME_WIDTH-1] uart_rx_dout,
  input  logic                   uart_rx_done,
  input  logic                   uart_rx_data_error,
  input  logic                   uart_rx_frame_error,
  input  logic                   uart_tx_done,
  output logic                   uart_tx_en,
  output logic [0:FRAME_WIDTH-1] uart_tx_din,
  output logic [LW-1:0]          fifo_level,
  output logic                   overflow,
  output logic                   busy
`ifdef UART_ECHO_ERR_CNT_EN
  ,
  output logic [7:0]             err_cnt
`endif
);

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_rx_done_d;
  logic                   r_overflow;
  logic [FRAME_WIDTH-1:0] r_tx_din;
  logic [FRAME_WIDTH-1:0] w_rx_frame;
  logic [FRAME_WIDTH-1:0] w_head;
  logic                   w_capture;
  logic                   w_err;
  logic                   w_good;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [LW-1:0]          w_level;

  // One event per frame: rising edge of the rx_done level.
  assign w_capture  = uart_rx_done & ~r_rx_done_d;
  assign w_err      = uart_rx_data_error | uart_rx_frame_error;
  assign w_good     = w_capture & ~((DROP_ERRORED != 0) & w_err);
  assign w_pop      = (r_state == ST_LOAD);
  assign w_rx_frame = uart_rx_dout;

  uart_sync_fifo #(
    .WIDTH (FRAME_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (sys_clk),
    .i_rst   (reset),
    .i_push  (w_good),
    .i_wdata (w_rx_frame),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rx_done_d <= 1'b0;
      r_overflow  <= 1'b0;
      r_tx_din    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_rx_done_d <= uart_rx_done;
      // Lost only if no pop frees a slot in the same cycle.
      if (w_good & w_full & ~w_pop) r_overflow <= 1'b1;
      if (w_pop) r_tx_din <= w_head;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:      if (!w_empty && uart_tx_done) w_state_next = ST_LOAD;
      ST_LOAD:      w_state_next = ST_SEND;
      ST_SEND:      if (!uart_tx_done) w_state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (uart_tx_done) w_state_next = ST_IDLE;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  // Decoded from state so an asynchronous reset drops the request at once.
  assign uart_tx_en  = (r_state == ST_SEND);
  assign uart_tx_din = r_tx_din;
  assign fifo_level  = w_level;
  assign overflow    = r_overflow;
  assign busy        = (r_state != ST_IDLE) | ~w_empty;

`ifdef UART_ECHO_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= 8'd0;
    end else if (w_capture && w_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_uart_echo_responder.sv
// ---------------------------------------------------------------------------
// tb_uart_echo_responder
// Directed stimulus against a queue-based reference of the echo responder:
// accepted frames enter a bounded queue, each transmit request must carry
// the queue head, level/overflow are compared every cycle. Directed tests
// pin the reference with literal expectations.
// ---------------------------------------------------------------------------
module tb_uart_echo_responder;

  localparam int FW    = 10;
  localparam int DEPTH = 8;
  localparam int LW    = 4;
  localparam int DROP  = 1;

  logic          sys_clk = 1'b0;
  logic          reset = 1'b1;
  logic [0:FW-1] uart_rx_dout = '0;
  logic          uart_rx_done = 1'b0;
  logic          uart_rx_data_error = 1'b0;
  logic          uart_rx_frame_error = 1'b0;
  logic          uart_tx_done = 1'b1;
  logic          uart_tx_en;
  logic [0:FW-1] uart_tx_din;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          busy;
`ifdef UART_ECHO_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  uart_echo_responder #(
    .FRAME_WIDTH  (FW),
    .FIFO_DEPTH   (DEPTH),
    .DROP_ERRORED (DROP)
  ) dut (
    .sys_clk             (sys_clk),
    .reset               (reset),
    .uart_rx_dout        (uart_rx_dout),
    .uart_rx_done        (uart_rx_done),
    .uart_rx_data_error  (uart_rx_data_error),
    .uart_rx_frame_error (uart_rx_frame_error),
    .uart_tx_done        (uart_tx_done),
    .uart_tx_en          (uart_tx_en),
    .uart_tx_din         (uart_tx_din),
    .fifo_level          (fifo_level),
    .overflow            (overflow),
    .busy                (busy)
`ifdef UART_ECHO_ERR_CNT_EN
    ,
    .err_cnt             (err_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- simple transmitter model (stimulus only) --------------
  logic tx_hold = 1'b0;
  int   tx_cnt  = 0;

  always @(negedge sys_clk) begin
    if (tx_hold) begin
      uart_tx_done = 1'b0;
      tx_cnt = 0;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) uart_tx_done = 1'b1;
    end else if (uart_tx_en && uart_tx_done) begin
      uart_tx_done = 1'b0;
      tx_cnt = 4;
    end else begin
      uart_tx_done = 1'b1;
    end
  end

  // ---------------- reference model + per-cycle compare -------------------
  logic [FW-1:0] m_q[$];
  logic [FW-1:0] echo_log[$];
  logic          m_ovf = 1'b0;
  logic          m_prev_done = 1'b0;
  logic          m_tx_en_prev = 1'b0;
  logic [FW-1:0] m_last_din = '0;
  int            m_errs = 0;

  initial begin
    logic          s_done, s_de, s_fe;
    logic [FW-1:0] s_dout;
    logic          cap, err;
    forever begin
      @(posedge sys_clk);
      s_done = uart_rx_done;
      s_de   = uart_rx_data_error;
      s_fe   = uart_rx_frame_error;
      s_dout = uart_rx_dout;
      #1;
      if (reset) begin
        m_q.delete();
        m_ovf        = 1'b0;
        m_prev_done  = 1'b0;
        m_tx_en_prev = 1'b0;
        m_last_din   = '0;
        m_errs       = 0;
      end else begin
        cap = s_done && !m_prev_done;
        m_prev_done = s_done;
        // A new transmit request consumes the queue head.
        if (uart_tx_en && !m_tx_en_prev) begin
          if (m_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_echo: got 0x%0h, expected no transmit", uart_tx_din);
          end else begin
            check("echo_data", uart_tx_din, m_q[0]);
            echo_log.push_back(uart_tx_din);
            m_last_din = m_q.pop_front();
          end
        end else if (uart_tx_en) begin
          check("tx_din_stable", uart_tx_din, m_last_din);
        end
        if (cap) begin
          err = s_de | s_fe;
          if (err && m_errs < 255) m_errs++;
          if (!(DROP != 0 && err)) begin
            if (m_q.size() < DEPTH) m_q.push_back(s_dout);
            else m_ovf = 1'b1;
          end
        end
        m_tx_en_prev = uart_tx_en;
      end
      check("fifo_level", fifo_level, m_q.size());
      check("overflow", overflow, m_ovf);
`ifdef UART_ECHO_ERR_CNT_EN
      check("err_cnt", err_cnt, m_errs);
`endif
    end
  end

  // ---------------- helpers ----------------
  task automatic send_frame(input logic [FW-1:0] val, input logic de, input logic fe,
                            input int hold);
    @(negedge sys_clk);
    uart_rx_dout = val;
    uart_rx_data_error = de;
    uart_rx_frame_error = fe;
    uart_rx_done = 1'b1;
    repeat (hold) @(negedge sys_clk);
    uart_rx_done = 1'b0;
    uart_rx_data_error = 1'b0;
    uart_rx_frame_error = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge sys_clk);
    while ((busy || fifo_level != 0 || !uart_tx_done) && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    check({name, "_drain_timeout"}, (n >= 3000), 0);
  endtask

  task automatic set_hold(input logic v);
    @(negedge sys_clk);
    #1 tx_hold = v;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    reset = 1'b1;
    repeat (2) @(negedge sys_clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin
    int log0, n, peak;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_tx_en", uart_tx_en, 0);
    check("rst_tx_din", uart_tx_din, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Single frame, latency of two edges after capture
    log0 = echo_log.size();
    @(negedge sys_clk);
    uart_rx_dout = 10'h155;
    uart_rx_done = 1'b1;
    @(posedge sys_clk); #1;
    check("lat_cap_tx_en", uart_tx_en, 0);
    check("lat_cap_level", fifo_level, 1);
    @(posedge sys_clk); #1;
    check("lat_load_tx_en", uart_tx_en, 0);
    @(posedge sys_clk); #1;
    check("lat_send_tx_en", uart_tx_en, 1);
    check("lat_send_din", uart_tx_din, 10'h155);
    @(negedge sys_clk);
    uart_rx_done = 1'b0;
    wait_idle("single");
    check("single_level", fifo_level, 0);
    check("single_overflow", overflow, 0);
    check("single_count", echo_log.size() - log0, 1);
    $display("txn single: sent 0x155 echoed %0d frame(s)", echo_log.size() - log0);

    // Long rx_done
    log0 = echo_log.size();
    peak = 0;
    @(negedge sys_clk);
    uart_rx_dout = 10'h0AA;
    uart_rx_done = 1'b1;
    repeat (50) begin
      @(negedge sys_clk);
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    uart_rx_done = 1'b0;
    wait_idle("long");
    check("long_count", echo_log.size() - log0, 1);
    check("long_peak", peak, 1);
    check("long_data", echo_log[echo_log.size()-1], 10'h0AA);
    $display("txn long_done: sent 0x0AA echoed %0d frame(s), peak level %0d",
             echo_log.size() - log0, peak);

    // Errored frame dropped
    log0 = echo_log.size();
    send_frame(10'h3FF, 1'b0, 1'b1, 2);
    send_frame(10'h001, 1'b0, 1'b0, 2);
    wait_idle("err");
    check("err_count", echo_log.size() - log0, 1);
    check("err_data", echo_log[echo_log.size()-1], 10'h001);
`ifdef UART_ECHO_ERR_CNT_EN
    check("err_cnt_lit", err_cnt, 1);
`endif
    $display("txn errored: sent 0x3FF(err),0x001 echoed %0d frame(s)", echo_log.size() - log0);

    // Overflow
    log0 = echo_log.size();
    set_hold(1'b1);
    for (int i = 1; i <= 9; i++) send_frame(FW'(i), 1'b0, 1'b0, 1);
    @(negedge sys_clk);
    check("ovf_level", fifo_level, 8);
    check("ovf_flag", overflow, 1);
    set_hold(1'b0);
    wait_idle("ovf");
    check("ovf_count", echo_log.size() - log0, 8);
    for (int i = 0; i < 8; i++) check("ovf_order", echo_log[log0+i], i + 1);
    check("ovf_sticky", overflow, 1);
    $display("txn overflow: sent 1..9 echoed %0d frame(s)", echo_log.size() - log0);

    // Reset mid-SEND (overflow is still set from the previous test)
    send_frame(10'h111, 1'b0, 1'b0, 1);
    n = 0;
    while (!uart_tx_en && n < 20) begin
      @(posedge sys_clk); #1;
      n++;
    end
    check("rsend_reach_send", (n >= 20), 0);
    #1 reset = 1'b1;
    #1;
    check("rsend_tx_en", uart_tx_en, 0);
    check("rsend_level", fifo_level, 0);
    check("rsend_overflow", overflow, 0);
    check("rsend_busy", busy, 0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    reset = 1'b0;
    log0 = echo_log.size();
    send_frame(10'h2C3, 1'b0, 1'b0, 1);
    wait_idle("rsend");
    check("rsend_count", echo_log.size() - log0, 1);
    check("rsend_data", echo_log[echo_log.size()-1], 10'h2C3);
    $display("txn reset_mid_send: post-reset 0x2C3 echoed %0d frame(s)", echo_log.size() - log0);

    // Simultaneous push/pop at full
    do_reset();
    log0 = echo_log.size();
    set_hold(1'b1);
    for (int i = 0; i < 8; i++) send_frame(FW'(10'h10 + i), 1'b0, 1'b0, 1);
    @(negedge sys_clk);
    check("simul_pre_level", fifo_level, 8);
    #1 tx_hold = 1'b0;
    @(negedge sys_clk);           // transmitter reports ready here
    @(negedge sys_clk);           // FSM has moved to LOAD on the edge between
    uart_rx_dout = 10'h0A5;
    uart_rx_done = 1'b1;
    @(posedge sys_clk); #1;       // capture coincides with the pop
    check("simul_level", fifo_level, 8);
    check("simul_overflow", overflow, 0);
    @(negedge sys_clk);
    uart_rx_done = 1'b0;
    wait_idle("simul");
    check("simul_count", echo_log.size() - log0, 9);
    check("simul_first", echo_log[log0], 10'h010);
    check("simul_last", echo_log[echo_log.size()-1], 10'h0A5);
    check("simul_overflow_end", overflow, 0);
    $display("txn simul_full: 0x10..0x17 + 0x0A5 echoed %0d frame(s)", echo_log.size() - log0);

    repeat (3) @(negedge sys_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_echo_responder.md
Name: uart_echo_responder

Overview:
- Far-end responder for the UART link: consumes frames from uart_rx_top and re-transmits each good frame through uart_tx_top (echo/loopback).
- Frames are buffered in a small FIFO so back-to-back receptions survive while the transmitter is busy.
- Lets a bench or host initiator close the loop over a single wire pair and check round-trip integrity.

Parameters:
- FRAME_WIDTH, 10, payload bits per frame (matches uart_rx_top/uart_tx_top).
- FIFO_DEPTH, 8, buffered frames; power of two, minimum 2.
- DROP_ERRORED, 1, 1 = discard frames flagged with data or frame error; 0 = echo them anyway.

Ports:
- sys_clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- uart_rx_dout  input  [0:FRAME_WIDTH-1]  received frame from uart_rx_top.
- uart_rx_done  input  1  level from uart_rx_top; high while uart_rx_dout is valid.
- uart_rx_data_error  input  1  parity/data error for the current frame.
- uart_rx_frame_error  input  1  stop-bit error for the current frame.
- uart_tx_done  input  1  high = uart_tx_top idle and ready.
- uart_tx_en  output  1  transmit request to uart_tx_top.
- uart_tx_din  output  [0:FRAME_WIDTH-1]  frame to transmit.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  frames currently buffered.
- overflow  output  1  sticky: a good frame was lost because the FIFO was full.
- busy  output  1  high when FSM is not IDLE or fifo_level != 0.

Behaviour:
- Reset, asynchronous: uart_tx_en=0, uart_tx_din=0, fifo_level=0, overflow=0, busy=0, FSM=IDLE. Read/write pointers and the rx_done delay register clear; FIFO contents are discarded. Reset during SEND drops uart_tx_en immediately.
- Capture:
  - rx_done_d registers uart_rx_done.
  - A capture event is uart_rx_done & ~rx_done_d, so exactly one event per frame however long rx_done stays high.
  - At that edge, frame, data_error and frame_error are sampled together.
- Errored frame: if DROP_ERRORED=1 and either error bit is set, the frame is not written.
- Write: the frame is written at the capture edge. fifo_level increments at that same edge.
- Full FIFO on capture: the frame is dropped, overflow sets and holds until reset. Pointers and level are unchanged.
- Simultaneous write and pop in one cycle: both occur, fifo_level unchanged. At full, a same-cycle pop frees the slot and the write succeeds (no overflow).
- Pointers: log2(FIFO_DEPTH) bits, natural wrap. Full means level == FIFO_DEPTH; empty means level == 0.
- FSM states: IDLE, LOAD, SEND, WAIT_DONE.
  - IDLE: if level != 0 and uart_tx_done=1, go to LOAD.
  - LOAD: pop head into the uart_tx_din register, level decrements, go to SEND.
  - SEND: uart_tx_en=1, uart_tx_din held stable. When uart_tx_done samples 0 (transmitter accepted), deassert uart_tx_en and go to WAIT_DONE.
  - WAIT_DONE: when uart_tx_done=1, go to IDLE.
- Latency: with tx idle, uart_tx_en rises 2 sys_clk edges after the capture edge (IDLE->LOAD, LOAD->SEND).
- uart_tx_din keeps its last value outside LOAD; it changes only in LOAD.
- Echo order is strictly FIFO; no reordering or duplication.

Optional Feature:
- Macro: UART_ECHO_ERR_CNT_EN.
- Defined: adds output err_cnt [7:0], reset 0. It increments (saturating at 255) on every capture event with either error bit set, regardless of DROP_ERRORED.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/include (uart_pkg): FSM state encodings (ST_IDLE, ST_LOAD, ST_SEND, ST_WAIT_DONE), the clog2 function, and the FRAME_WIDTH default constant shared with the tx/rx tops.
- One natural sub-module: uart_sync_fifo, the parameterised width/depth FIFO with push, pop, full, empty and level. Reusable later on the tx command path.

Test Plan:
- Single frame: rx frame 0x155 with no errors, tx idle -> uart_tx_en rises 2 cycles after capture, uart_tx_din=0x155, fifo_level returns to 0, overflow=0.
- Long rx_done: rx_done held high 50 cycles for frame 0x0AA -> exactly one echo, fifo_level peaks at 1.
- Errored frames, DROP_ERRORED=1: frame 0x3FF with frame_error=1, then 0x001 clean -> only 0x001 echoed. With UART_ECHO_ERR_CNT_EN, err_cnt=1.
- Overflow: tx_done held 0, 9 clean frames 1..9 -> fifo_level=8, overflow=1. Release tx_done -> frames 1..8 echoed in order, frame 9 never sent.
- Simultaneous push/pop at full: level=8, capture coincides with LOAD -> level stays 8, overflow stays 0, new frame echoed last.
- Reset mid-SEND: assert reset while uart_tx_en=1 -> uart_tx_en=0 asynchronously, fifo_level=0, overflow=0. After release, new frame 0x2C3 echoes normally.
